div_unit: RTL and testbench
===========================

# div_unit

Parametrised multi-cycle restoring divider for the OpenMIPS execute stage. It serves DIV and DIVU, replacing the fixed 32-bit divider, and adds a usable annul path so a flushed divide can be aborted mid-operation. The execute stage drives operands and holds `start_i` high until `ready_o`. The result is packed as {remainder, quotient}, which is the {HI, LO} layout the HI/LO write path expects.

## Interface
- `WIDTH`, default 32: operand width in bits. Legal values are even and ≥4.
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `signed_div_i  in  1`: 1 selects a signed (DIV) operation, 0 selects unsigned (DIVU).
- `opdata1_i  in  WIDTH`: dividend.
- `opdata2_i  in  WIDTH`: divisor.
- `start_i  in  1`: operation request. Held high by the requester until `ready_o`, then dropped.
- `annul_i  in  1`: abort the current or requested operation.
- `result_o  out  2*WIDTH`: {remainder, quotient}. Valid only while `ready_o`=1, otherwise 0.
- `ready_o  out  1`: result valid.
- `busy_o  out  1`: high in the DIVIDE state.
- `dz_o  out  1`: divide-by-zero flag. Present only with `DIV_DZ_FLAG_EN`.

## Operation
- **States:** IDLE, DIVIDE, DONE. Reset places the block in IDLE.
- **Reset values:** `result_o`=0, `ready_o`=0, `busy_o`=0, `dz_o`=0. All internal registers are cleared.
- **IDLE:**
  - If `start_i`=1, `annul_i`=0 and `opdata2_i`≠0: latch the operand magnitudes, latch the sign info, set the iteration count to 0, and go to DIVIDE.
  - If `start_i`=1, `annul_i`=0 and `opdata2_i`=0: go directly to DONE with result 0.
  - If `start_i`=1 and `annul_i`=1: the request is ignored and the block stays in IDLE.
- **Sign handling (signed mode only):**
  - Operands are converted to magnitudes by two's-complement negation when their MSB is 1.
  - Quotient sign is the XOR of the operand signs.
  - Remainder takes the sign of the dividend.
- **DIVIDE:**
  - One restoring step per cycle, producing one quotient bit MSB-first.
  - Each step shifts the {partial remainder, dividend} register left by 1, then computes the trial subtraction `partial_rem − divisor` using WIDTH+1 bits.
  - If the trial is non-negative, the partial remainder takes the difference and the quotient bit is 1. Otherwise the partial remainder is kept and the quotient bit is 0.
  - After WIDTH steps: apply sign correction, go to DONE.
- **Annul during DIVIDE:** `annul_i`=1 returns the block to IDLE at the next edge. No result is produced and `ready_o` stays 0.
- **DONE:**
  - `ready_o`=1 and `result_o` is held for as long as `start_i`=1.
  - When `start_i`=0: return to IDLE at the next edge, with `ready_o` and `result_o` cleared.
  - `annul_i` in DONE has the same effect as `start_i`=0.
- **Requests while busy:** changes to `start_i` or the operands during DIVIDE are ignored, because the operands were latched in IDLE.
- **Overflow case:** signed most-negative ÷ −1 gives quotient = most-negative (wraps) and remainder 0. This case is not flagged.
- **Reset mid-operation:** a synchronous `rst` in any state returns the block to IDLE with all outputs 0 at that edge.

## Timing
- Call the edge that samples `start_i` in IDLE "edge 0".
- **Nonzero divisor:** the steps execute on edges 1..WIDTH. DONE is entered at edge WIDTH+1, and `ready_o` is high in the cycle after that edge. Total latency is WIDTH+1 cycles (33 for WIDTH=32).
- **Zero divisor:** DONE is entered at edge 1, so `ready_o` is high after 1 cycle.
- **Outputs:** all outputs are registered. There is no combinational path from any input to any output.
- **Back-to-back operations:** the minimum gap between two operations is one IDLE cycle. `start_i` must be seen low in DONE before the next request.
- **Annul precedence:** `annul_i` takes priority over DIVIDE progress on the same edge. An annul on edge WIDTH produces no result.

## Configuration
- **`DIV_DZ_FLAG_EN`:**
  - **Defined:** the `dz_o` port exists. It is asserted together with `ready_o` when the latched divisor was 0, and cleared with `ready_o`. The result is still 0.
  - **Undefined:** the `dz_o` port and its register are absent. Divide-by-zero is indistinguishable from a zero result.

## Test plan
- **Unsigned basic:** WIDTH=32, DIVU 100/7 → `ready_o` after 33 cycles; `result_o` = {0x00000002, 0x0000000E}.
- **Signed mixed signs:** DIV −7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Then 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- **Divide by zero:** DIVU 5/0 → `ready_o` after 1 cycle, `result_o`=0, `dz_o`=1 (with `DIV_DZ_FLAG_EN`). Drop `start_i` → `ready_o`=0 at the next cycle.
- **Annul:** start 1000/3, assert `annul_i` on edge 5 → `ready_o` never rises, state is IDLE. A following 9/3 request returns {0, 3} after 33 cycles.
- **Overflow:** DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- **Parameterisation and reset:** with WIDTH=8, DIVU 200/3 → {0x02, 0x42} after 9 cycles. Asserting `rst` on edge 4 of a second divide → all outputs 0 and IDLE at the next cycle.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU with annul; result is {remainder, quotient}.
// Define DIV_DZ_FLAG_EN to add the dz_o divide-by-zero flag.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
`ifdef DIV_DZ_FLAG_EN
  ,
  output logic               dz_o
`endif
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH:0]   rem_r;
  logic [CNT_W-1:0] cnt_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             zero_pend_r;

  logic             sign1_s;
  logic             sign2_s;
  logic [WIDTH-1:0] mag1_s;
  logic [WIDTH-1:0] mag2_s;
  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] trial_s;
  logic [WIDTH-1:0] quot_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic             accept_s;
  logic             go_idle_s;

  // Operand magnitudes, one restoring trial step and final sign correction.
  always_comb begin
    sign1_s   = signed_div_i & opdata1_i[WIDTH-1];
    sign2_s   = signed_div_i & opdata2_i[WIDTH-1];
    mag1_s    = sign1_s ? (~opdata1_i + ONE_W) : opdata1_i;
    mag2_s    = sign2_s ? (~opdata2_i + ONE_W) : opdata2_i;
    shifted_s = {rem_r, dvd_r[WIDTH-1]};
    trial_s   = shifted_s - {2'b00, dsr_r};
    quot_s    = q_neg_r ? (~dvd_r + ONE_W) : dvd_r;
    rem_fix_s = r_neg_r ? (~rem_r[WIDTH-1:0] + ONE_W) : rem_r[WIDTH-1:0];
    accept_s  = start_i & ~annul_i;
    go_idle_s = ~start_i | annul_i;
  end

  // Control FSM; the quotient bits shift into dvd_r as the dividend bits shift out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      dvd_r       <= ZERO_W;
      dsr_r       <= ZERO_W;
      rem_r       <= {(WIDTH+1){1'b0}};
      cnt_r       <= CNT_ZERO;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      zero_pend_r <= 1'b0;
      result_o    <= {(2*WIDTH){1'b0}};
      ready_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // A zero divisor spends one cycle pending so DONE lands on the edge after the request.
          if (zero_pend_r) begin
            zero_pend_r <= 1'b0;
            if (!annul_i) begin
              result_o <= {(2*WIDTH){1'b0}};
              ready_o  <= 1'b1;
              state_r  <= DONE;
            end
          end else if (accept_s) begin
            if (opdata2_i != ZERO_W) begin
              dvd_r   <= mag1_s;
              dsr_r   <= mag2_s;
              rem_r   <= {(WIDTH+1){1'b0}};
              cnt_r   <= CNT_ZERO;
              q_neg_r <= sign1_s ^ sign2_s;
              r_neg_r <= sign1_s;
              busy_o  <= 1'b1;
              state_r <= DIVIDE;
            end else begin
              zero_pend_r <= 1'b1;
            end
          end
        end
        DIVIDE: begin
          if (annul_i) begin
            busy_o  <= 1'b0;
            state_r <= IDLE;
          end else if (cnt_r == LAST_CNT) begin
            result_o <= {rem_fix_s, quot_s};
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
            state_r  <= DONE;
          end else begin
            if (!trial_s[WIDTH+1]) begin
              rem_r <= trial_s[WIDTH:0];
              dvd_r <= {dvd_r[WIDTH-2:0], 1'b1};
            end else begin
              rem_r <= shifted_s[WIDTH:0];
              dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
            end
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          if (go_idle_s) begin
            result_o <= {(2*WIDTH){1'b0}};
            ready_o  <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          result_o    <= {(2*WIDTH){1'b0}};
          ready_o     <= 1'b0;
          busy_o      <= 1'b0;
          zero_pend_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef DIV_DZ_FLAG_EN
  // Divide-by-zero flag rises with ready_o on the zero-divisor path and falls with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dz_o <= 1'b0;
    end else if (state_r == IDLE && zero_pend_r && !annul_i) begin
      dz_o <= 1'b1;
    end else if (state_r == DONE && go_idle_s) begin
      dz_o <= 1'b0;
    end else begin
      dz_o <= dz_o;
    end
  end
`endif

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: WIDTH=32 and WIDTH=8 instances against an arithmetic reference.
module tb_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sg32, st32, an32, rdy32, bsy32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        sg8, st8, an8, rdy8, bsy8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
`ifdef DIV_DZ_FLAG_EN
  logic        dz32, dz8;
`endif

  int total = 0;
  int bad   = 0;

  div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sg32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32), .busy_o(bsy32)
`ifdef DIV_DZ_FLAG_EN
    , .dz_o(dz32)
`endif
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sg8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8), .busy_o(bsy8)
`ifdef DIV_DZ_FLAG_EN
    , .dz_o(dz8)
`endif
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder follows dividend.
  function automatic logic [63:0] ref_div(int w, bit sgn, logic [31:0] a, logic [31:0] b);
    longint m, sa, sb, q, r;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sb == 0) return 64'd0;
    if (sgn) begin
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    end
    q = sa / sb;
    r = sa % sb;
    return 64'(((r & m) << w) | (q & m));
  endfunction

  function automatic logic get_rdy(int w);
    return (w == 8) ? rdy8 : rdy32;
  endfunction

  function automatic logic get_busy(int w);
    return (w == 8) ? bsy8 : bsy32;
  endfunction

  function automatic logic [63:0] get_res(int w);
    return (w == 8) ? {48'd0, res8} : res32;
  endfunction

  function automatic logic get_dz(int w);
`ifdef DIV_DZ_FLAG_EN
    return (w == 8) ? dz8 : dz32;
`else
    return (w == 8) ? 1'b0 : 1'b0;
`endif
  endfunction

  task automatic drive(int w, bit sgn, logic [31:0] a, logic [31:0] b, bit st, bit an);
    if (w == 8) begin
      sg8 = sgn; a8 = a[7:0]; b8 = b[7:0]; st8 = st; an8 = an;
    end else begin
      sg32 = sgn; a32 = a; b32 = b; st32 = st; an32 = an;
    end
  endtask

  // Full request/response handshake; operands are scrambled while the divide is in flight.
  task automatic op(int w, bit sgn, logic [31:0] a, logic [31:0] b, string tag);
    logic [63:0] exp_res;
    bit          zero;
    int          n, want, hold;
    zero    = (w == 8) ? (b[7:0] == 8'd0) : (b == 32'd0);
    exp_res = ref_div(w, sgn, a, b);
    // DONE is entered at edge 1 (zero) or edge w+1; the negedge after edge k is n = k+1.
    want    = zero ? 2 : w + 2;
    @(negedge clk);
    drive(w, sgn, a, b, 1'b1, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!get_rdy(w)) begin
        chk({tag, ":busy"}, 64'(get_busy(w)), 64'(!zero));
        chk({tag, ":res_not_ready"}, get_res(w), 64'd0);
        drive(w, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1, 1'b0);
      end
    end while (!get_rdy(w) && n < 3 * w);
    chk({tag, ":latency"}, 64'(n), 64'(want));
    chk({tag, ":result"}, get_res(w), exp_res);
    chk({tag, ":busy_done"}, 64'(get_busy(w)), 64'd0);
`ifdef DIV_DZ_FLAG_EN
    chk({tag, ":dz"}, 64'(get_dz(w)), 64'(zero));
`endif
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ":held_ready"}, 64'(get_rdy(w)), 64'd1);
      chk({tag, ":held_result"}, get_res(w), exp_res);
    end
    drive(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk({tag, ":ready_drop"}, 64'(get_rdy(w)), 64'd0);
    chk({tag, ":result_drop"}, get_res(w), 64'd0);
    chk({tag, ":dz_drop"}, 64'(get_dz(w)), 64'd0);
  endtask

  initial begin
    bit seen;
    logic [31:0] ra, rb;
    rst = 1'b1;
    drive(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset:ready32", 64'(rdy32), 64'd0);
    chk("reset:busy32", 64'(bsy32), 64'd0);
    chk("reset:result32", res32, 64'd0);
    chk("reset:ready8", 64'(rdy8), 64'd0);
    chk("reset:result8", 64'(res8), 64'd0);
    chk("reset:dz32", 64'(get_dz(32)), 64'd0);
    rst = 1'b0;

    op(32, 1'b0, 32'd100, 32'd7, "divu_100_7");
    op(32, 1'b1, -32'sd7, 32'd2, "div_m7_2");
    op(32, 1'b1, 32'd7, -32'sd2, "div_7_m2");
    op(32, 1'b0, 32'd5, 32'd0, "divu_5_0");
    op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    op(32, 1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    op(32, 1'b0, 32'd3, 32'hFFFF_FFFF, "divu_small_big");
    op(32, 1'b1, 32'h8000_0000, 32'd1, "div_minneg_1");

    // Annul at edge 5 of a 1000/3 divide.
    @(negedge clk);
    drive(32, 1'b0, 32'd1000, 32'd3, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    an32 = 1'b1;
    @(negedge clk);
    st32 = 1'b0;
    an32 = 1'b0;
    chk("annul5:busy", 64'(bsy32), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy32 || bsy32) seen = 1'b1;
    end
    chk("annul5:no_result", 64'(seen), 64'd0);
    op(32, 1'b0, 32'd9, 32'd3, "after_annul_9_3");

    // Request with annul already high is ignored.
    @(negedge clk);
    drive(32, 1'b0, 32'd20, 32'd4, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("start_annul:busy", 64'(bsy32), 64'd0);
    chk("start_annul:ready", 64'(rdy32), 64'd0);
    drive(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    op(8, 1'b0, 32'd200, 32'd3, "w8_divu_200_3");

    // Annul on edge WIDTH (last step) of an 8-bit divide.
    @(negedge clk);
    drive(8, 1'b0, 32'd77, 32'd5, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    an8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    an8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rdy8 || bsy8) seen = 1'b1;
    end
    chk("annul_last:no_result", 64'(seen), 64'd0);

    // Annul while DONE acts like dropping start.
    @(negedge clk);
    drive(8, 1'b1, 32'd50, 32'hF9, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rdy8;
    end
    chk("annul_done:ready_seen", 64'(seen), 64'd1);
    chk("annul_done:result", 64'(res8), ref_div(8, 1'b1, 32'd50, 32'hF9));
    an8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    an8 = 1'b0;
    chk("annul_done:ready", 64'(rdy8), 64'd0);
    chk("annul_done:result_clr", 64'(res8), 64'd0);

    // Synchronous reset on edge 4 of a divide.
    @(negedge clk);
    drive(8, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid:busy", 64'(bsy8), 64'd0);
    chk("rst_mid:ready", 64'(rdy8), 64'd0);
    chk("rst_mid:result", 64'(res8), 64'd0);
    rst = 1'b0;
    st8 = 1'b0;
    @(negedge clk);
    chk("rst_mid:idle", 64'(bsy8), 64'd0);
    op(8, 1'b1, 32'h80, 32'hFF, "w8_overflow");

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = (i == 6) ? 32'd0 : ($urandom >> 20);
        default: rb = -32'($urandom_range(1, 9));
      endcase
      op(32, 1'($urandom_range(0, 1)), ra, rb, "rand32");
    end
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = (i % 8 == 3) ? 32'd0 : $urandom;
      op(8, 1'($urandom_range(0, 1)), ra, rb, "rand8");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
